// File: rtl/motion_pkg.sv
// Shared types and constants for the object motion bank.
// Edge modes, playfield defaults and lane index sizing.
package motion_pkg;

    typedef enum logic {
        MODE_BOUNCE = 1'b0,
        MODE_EXIT   = 1'b1
    } mode_e;

    localparam int SCREEN_W_DEF = 640;
    localparam int SCREEN_H_DEF = 480;

    // Width of a lane index; a single lane still gets one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/object_motion_lane.sv
// One moving object: two step-period counters, edge detect,
// bounce/exit handling, kill and spawn load.
module object_motion_lane
    import motion_pkg::*;
#(
    parameter int X_W      = 10,
    parameter int Y_W      = 9,
    parameter int T_W      = 32,
    parameter int SCREEN_W = SCREEN_W_DEF,
    parameter int SCREEN_H = SCREEN_H_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load_i,
    input  logic           kill_i,
    input  logic           pause_i,
    input  logic [X_W-1:0] obj_w_i,
    input  logic [Y_W-1:0] obj_h_i,
    input  logic [X_W-1:0] sx_i,
    input  logic [Y_W-1:0] sy_i,
    input  logic [T_W-1:0] stx_i,
    input  logic [T_W-1:0] sty_i,
    input  logic           sdx_i,
    input  logic           sdy_i,
    input  logic           smode_i,
    output logic           active_o,
    output logic [X_W-1:0] x_o,
    output logic [Y_W-1:0] y_o,
    output logic           exit_pulse_o
);

    localparam logic [X_W:0] SW = (X_W+1)'(SCREEN_W);
    localparam logic [Y_W:0] SH = (Y_W+1)'(SCREEN_H);

    logic           active_q, active_d;
    logic           pulse_q,  pulse_d;
    logic [X_W-1:0] x_q,  x_d;
    logic [Y_W-1:0] y_q,  y_d;
    logic           dx_q, dx_d;
    logic           dy_q, dy_d;
    mode_e          mode_q, mode_d;
    logic [T_W-1:0] tx_q, tx_d;
    logic [T_W-1:0] ty_q, ty_d;
    logic [T_W-1:0] cx_q, cx_d;
    logic [T_W-1:0] cy_q, cy_d;

    logic           tick_x, tick_y;
    logic           edge_x, edge_y;
    logic           hit_x,  hit_y;
    logic [X_W:0]   far_x;
    logic [Y_W:0]   far_y;

    // Step ticks and edge detection; far edge summed one bit wider.
    always_comb begin
        far_x  = {1'b0, x_q} + {1'b0, obj_w_i};
        far_y  = {1'b0, y_q} + {1'b0, obj_h_i};
        tick_x = (tx_q != '0) && (cx_q == tx_q - T_W'(1));
        tick_y = (ty_q != '0) && (cy_q == ty_q - T_W'(1));
        edge_x = dx_q ? (far_x >= SW) : (x_q == '0);
        edge_y = dy_q ? (far_y >= SH) : (y_q == '0);
        hit_x  = tick_x && edge_x;
        hit_y  = tick_y && edge_y;
    end

    // Next state: spawn load, kill, then motion when running.
    always_comb begin
        active_d = active_q;
        pulse_d  = 1'b0;
        x_d      = x_q;
        y_d      = y_q;
        dx_d     = dx_q;
        dy_d     = dy_q;
        mode_d   = mode_q;
        tx_d     = tx_q;
        ty_d     = ty_q;
        cx_d     = cx_q;
        cy_d     = cy_q;
        if (load_i) begin
            active_d = 1'b1;
            x_d      = sx_i;
            y_d      = sy_i;
            dx_d     = sdx_i;
            dy_d     = sdy_i;
            mode_d   = mode_e'(smode_i);
            tx_d     = stx_i;
            ty_d     = sty_i;
            cx_d     = '0;
            cy_d     = '0;
        end else if (active_q) begin
            if (kill_i) begin
                active_d = 1'b0;
                cx_d     = '0;
                cy_d     = '0;
            end else if (!pause_i) begin
                if (tx_q != '0) cx_d = tick_x ? '0 : cx_q + T_W'(1);
                if (ty_q != '0) cy_d = tick_y ? '0 : cy_q + T_W'(1);
                if (mode_q == MODE_EXIT && (hit_x || hit_y)) begin
                    active_d = 1'b0;
                    pulse_d  = 1'b1;
                    cx_d     = '0;
                    cy_d     = '0;
                end else begin
                    if (hit_x)       dx_d = ~dx_q;
                    else if (tick_x) x_d  = dx_q ? x_q + X_W'(1)
                                                 : x_q - X_W'(1);
                    if (hit_y)       dy_d = ~dy_q;
                    else if (tick_y) y_d  = dy_q ? y_q + Y_W'(1)
                                                 : y_q - Y_W'(1);
                end
            end
        end
    end

    // Lane state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            active_q <= 1'b0;
            pulse_q  <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            dx_q     <= 1'b0;
            dy_q     <= 1'b0;
            mode_q   <= MODE_BOUNCE;
            tx_q     <= '0;
            ty_q     <= '0;
            cx_q     <= '0;
            cy_q     <= '0;
        end else begin
            active_q <= active_d;
            pulse_q  <= pulse_d;
            x_q      <= x_d;
            y_q      <= y_d;
            dx_q     <= dx_d;
            dy_q     <= dy_d;
            mode_q   <= mode_d;
            tx_q     <= tx_d;
            ty_q     <= ty_d;
            cx_q     <= cx_d;
            cy_q     <= cy_d;
        end
    end

    assign active_o     = active_q;
    assign x_o          = x_q;
    assign y_o          = y_q;
    assign exit_pulse_o = pulse_q;

endmodule

// File: rtl/object_motion_bank.sv
// Bank of N_OBJ object lanes with a shared spawn port.
// Decodes spawn_id to a lane load and flattens position buses.
module object_motion_bank
    import motion_pkg::*;
#(
    parameter int N_OBJ    = 4,
    parameter int X_W      = 10,
    parameter int Y_W      = 9,
    parameter int T_W      = 32,
    parameter int SCREEN_W = SCREEN_W_DEF,
    parameter int SCREEN_H = SCREEN_H_DEF,
    parameter int IW       = idx_w(N_OBJ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pause,
    input  logic [X_W-1:0]     obj_w,
    input  logic [Y_W-1:0]     obj_h,
    input  logic               spawn_valid,
    output logic               spawn_ready,
    input  logic [IW-1:0]      spawn_id,
    input  logic [X_W-1:0]     spawn_x,
    input  logic [Y_W-1:0]     spawn_y,
    input  logic [T_W-1:0]     spawn_tx,
    input  logic [T_W-1:0]     spawn_ty,
    input  logic               spawn_dx,
    input  logic               spawn_dy,
    input  logic               spawn_mode,
    input  logic [N_OBJ-1:0]   kill,
    output logic [N_OBJ-1:0]   active,
    output logic [N_OBJ*X_W-1:0] posx,
    output logic [N_OBJ*Y_W-1:0] posy,
    output logic [N_OBJ-1:0]   exit_pulse
);

    logic accept;

    // Target lane must be free for a spawn to be accepted.
    always_comb begin
        spawn_ready = !active[spawn_id];
        accept      = spawn_valid && spawn_ready;
    end

    for (genvar i = 0; i < N_OBJ; i++) begin : g_lane
        logic load;
        assign load = accept && (spawn_id == IW'(i));

        object_motion_lane #(
            .X_W      (X_W),
            .Y_W      (Y_W),
            .T_W      (T_W),
            .SCREEN_W (SCREEN_W),
            .SCREEN_H (SCREEN_H)
        ) u_lane (
            .clk          (clk),
            .rst          (rst),
            .load_i       (load),
            .kill_i       (kill[i]),
            .pause_i      (pause),
            .obj_w_i      (obj_w),
            .obj_h_i      (obj_h),
            .sx_i         (spawn_x),
            .sy_i         (spawn_y),
            .stx_i        (spawn_tx),
            .sty_i        (spawn_ty),
            .sdx_i        (spawn_dx),
            .sdy_i        (spawn_dy),
            .smode_i      (spawn_mode),
            .active_o     (active[i]),
            .x_o          (posx[i*X_W +: X_W]),
            .y_o          (posy[i*Y_W +: Y_W]),
            .exit_pulse_o (exit_pulse[i])
        );
    end

endmodule

// File: tb/tb_object_motion_bank.sv
// Directed bench for object_motion_bank.
// Each task drives one scenario and checks hand-computed values.
module tb_object_motion_bank;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pause = 1'b0;
    logic [9:0]  obj_w = 10'd100;
    logic [8:0]  obj_h = 9'd80;
    logic        spawn_valid = 1'b0;
    logic        spawn_ready;
    logic [1:0]  spawn_id = 2'd0;
    logic [9:0]  spawn_x = '0;
    logic [8:0]  spawn_y = '0;
    logic [31:0] spawn_tx = '0;
    logic [31:0] spawn_ty = '0;
    logic        spawn_dx = 1'b0;
    logic        spawn_dy = 1'b0;
    logic        spawn_mode = 1'b0;
    logic [3:0]  kill = '0;
    logic [3:0]  active;
    logic [39:0] posx;
    logic [35:0] posy;
    logic [3:0]  exit_pulse;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    object_motion_bank dut (
        .clk         (clk),
        .rst         (rst),
        .pause       (pause),
        .obj_w       (obj_w),
        .obj_h       (obj_h),
        .spawn_valid (spawn_valid),
        .spawn_ready (spawn_ready),
        .spawn_id    (spawn_id),
        .spawn_x     (spawn_x),
        .spawn_y     (spawn_y),
        .spawn_tx    (spawn_tx),
        .spawn_ty    (spawn_ty),
        .spawn_dx    (spawn_dx),
        .spawn_dy    (spawn_dy),
        .spawn_mode  (spawn_mode),
        .kill        (kill),
        .active      (active),
        .posx        (posx),
        .posy        (posy),
        .exit_pulse  (exit_pulse)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] px(input int i);
        return posx[i*10 +: 10];
    endfunction

    function automatic logic [8:0] py(input int i);
        return posy[i*9 +: 9];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic spawn(input logic [1:0] id, input logic [9:0] x,
                         input logic [8:0] y, input logic [31:0] tx,
                         input logic [31:0] ty, input logic dx,
                         input logic dy, input logic mode);
        spawn_id    = id;
        spawn_x     = x;
        spawn_y     = y;
        spawn_tx    = tx;
        spawn_ty    = ty;
        spawn_dx    = dx;
        spawn_dy    = dy;
        spawn_mode  = mode;
        spawn_valid = 1'b1;
        step();
        spawn_valid = 1'b0;
    endtask

    task automatic kill_all();
        kill = 4'hF;
        step();
        kill = 4'h0;
    endtask

    task automatic test_reset();
        spawn_valid = 1'b1;
        spawn_id    = 2'd0;
        spawn_x     = 10'd33;
        spawn_y     = 9'd44;
        spawn_tx    = 32'd1;
        steps(3);
        chk_cnt++;
        if (active !== 4'b0)
            $display("FAIL reset_active got %b exp 0000", active);
        else pass_cnt++;
        chk_cnt++;
        if (posx !== '0 || posy !== '0)
            $display("FAIL reset_pos got %h/%h exp 0/0", posx, posy);
        else pass_cnt++;
        chk_cnt++;
        if (exit_pulse !== 4'b0)
            $display("FAIL reset_pulse got %b exp 0000", exit_pulse);
        else pass_cnt++;
        chk_cnt++;
        if (spawn_ready !== 1'b1)
            $display("FAIL reset_ready got %b exp 1", spawn_ready);
        else pass_cnt++;
        spawn_valid = 1'b0;
        rst = 1'b1;
        step();
        chk_cnt++;
        if (active !== 4'b0)
            $display("FAIL reset_release got %b exp 0000", active);
        else pass_cnt++;
    endtask

    task automatic test_basic();
        spawn(2'd0, 10'd0, 9'd0, 32'd4, 32'd8, 1'b1, 1'b1, 1'b0);
        chk_cnt++;
        if (active !== 4'b0001 || spawn_ready !== 1'b0)
            $display("FAIL basic_spawn got %b/%b exp 0001/0",
                     active, spawn_ready);
        else pass_cnt++;
        steps(3);
        chk_cnt++;
        if (px(0) !== 10'd0)
            $display("FAIL basic_x3 got %0d exp 0", px(0));
        else pass_cnt++;
        step();
        chk_cnt++;
        if (px(0) !== 10'd1 || py(0) !== 9'd0)
            $display("FAIL basic_c4 got %0d,%0d exp 1,0", px(0), py(0));
        else pass_cnt++;
        steps(3);
        chk_cnt++;
        if (py(0) !== 9'd0)
            $display("FAIL basic_y7 got %0d exp 0", py(0));
        else pass_cnt++;
        step();
        chk_cnt++;
        if (px(0) !== 10'd2 || py(0) !== 9'd1)
            $display("FAIL basic_c8 got %0d,%0d exp 2,1", px(0), py(0));
        else pass_cnt++;
        kill_all();
        chk_cnt++;
        if (active !== 4'b0 || exit_pulse !== 4'b0)
            $display("FAIL basic_kill got %b/%b exp 0000/0000",
                     active, exit_pulse);
        else pass_cnt++;
    endtask

    task automatic test_bounce();
        spawn(2'd1, 10'd540, 9'd10, 32'd2, 32'd0, 1'b1, 1'b0, 1'b0);
        step();
        chk_cnt++;
        if (px(1) !== 10'd540)
            $display("FAIL bounce_c1 got %0d exp 540", px(1));
        else pass_cnt++;
        step();
        chk_cnt++;
        if (px(1) !== 10'd540 || active[1] !== 1'b1)
            $display("FAIL bounce_edge got %0d/%b exp 540/1",
                     px(1), active[1]);
        else pass_cnt++;
        steps(2);
        chk_cnt++;
        if (px(1) !== 10'd539)
            $display("FAIL bounce_back got %0d exp 539", px(1));
        else pass_cnt++;
        steps(2);
        chk_cnt++;
        if (px(1) !== 10'd538 || py(1) !== 9'd10)
            $display("FAIL bounce_back2 got %0d,%0d exp 538,10",
                     px(1), py(1));
        else pass_cnt++;
        kill_all();
    endtask

    task automatic test_exit();
        spawn(2'd1, 10'd5, 9'd400, 32'd0, 32'd2, 1'b0, 1'b1, 1'b1);
        step();
        chk_cnt++;
        if (active[1] !== 1'b1 || exit_pulse !== 4'b0)
            $display("FAIL exit_c1 got %b/%b exp 1/0000",
                     active[1], exit_pulse);
        else pass_cnt++;
        step();
        chk_cnt++;
        if (active[1] !== 1'b0 || exit_pulse !== 4'b0010)
            $display("FAIL exit_pulse got %b/%b exp 0/0010",
                     active[1], exit_pulse);
        else pass_cnt++;
        chk_cnt++;
        if (py(1) !== 9'd400 || spawn_ready !== 1'b1)
            $display("FAIL exit_hold got %0d/%b exp 400/1",
                     py(1), spawn_ready);
        else pass_cnt++;
        spawn(2'd1, 10'd20, 9'd100, 32'd0, 32'd0, 1'b1, 1'b1, 1'b1);
        chk_cnt++;
        if (exit_pulse !== 4'b0 || active[1] !== 1'b1 || py(1) !== 9'd100)
            $display("FAIL exit_respawn got %b/%b/%0d exp 0000/1/100",
                     exit_pulse, active[1], py(1));
        else pass_cnt++;
        kill_all();
    endtask

    task automatic test_kill();
        spawn(2'd2, 10'd7, 9'd400, 32'd0, 32'd2, 1'b0, 1'b1, 1'b1);
        step();
        kill = 4'b0100;
        step();
        kill = 4'b0000;
        chk_cnt++;
        if (active[2] !== 1'b0 || exit_pulse !== 4'b0)
            $display("FAIL kill_edge got %b/%b exp 0/0000",
                     active[2], exit_pulse);
        else pass_cnt++;
        step();
        chk_cnt++;
        if (exit_pulse !== 4'b0)
            $display("FAIL kill_nopulse got %b exp 0000", exit_pulse);
        else pass_cnt++;
        kill = 4'b1000;
        step();
        kill = 4'b0000;
        chk_cnt++;
        if (active !== 4'b0 || px(3) !== 10'd0 || exit_pulse !== 4'b0)
            $display("FAIL kill_idle got %b/%0d/%b exp 0000/0/0000",
                     active, px(3), exit_pulse);
        else pass_cnt++;
    endtask

    task automatic test_pause();
        spawn(2'd0, 10'd10, 9'd20, 32'd3, 32'd5, 1'b1, 1'b1, 1'b0);
        steps(4);
        chk_cnt++;
        if (px(0) !== 10'd11 || py(0) !== 9'd20)
            $display("FAIL pause_pre got %0d,%0d exp 11,20", px(0), py(0));
        else pass_cnt++;
        pause = 1'b1;
        spawn(2'd3, 10'd50, 9'd60, 32'd1, 32'd1, 1'b1, 1'b1, 1'b0);
        steps(19);
        chk_cnt++;
        if (px(0) !== 10'd11 || py(0) !== 9'd20)
            $display("FAIL pause_hold0 got %0d,%0d exp 11,20", px(0), py(0));
        else pass_cnt++;
        chk_cnt++;
        if (active !== 4'b1001 || px(3) !== 10'd50 || py(3) !== 9'd60)
            $display("FAIL pause_spawn got %b/%0d,%0d exp 1001/50,60",
                     active, px(3), py(3));
        else pass_cnt++;
        pause = 1'b0;
        step();
        chk_cnt++;
        if (px(0) !== 10'd11 || py(0) !== 9'd21)
            $display("FAIL resume1_l0 got %0d,%0d exp 11,21", px(0), py(0));
        else pass_cnt++;
        chk_cnt++;
        if (px(3) !== 10'd51 || py(3) !== 9'd61)
            $display("FAIL resume1_l3 got %0d,%0d exp 51,61", px(3), py(3));
        else pass_cnt++;
        step();
        chk_cnt++;
        if (px(0) !== 10'd12 || px(3) !== 10'd52)
            $display("FAIL resume2 got %0d,%0d exp 12,52", px(0), px(3));
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk_cnt++;
        if (active !== 4'b0 || exit_pulse !== 4'b0)
            $display("FAIL midreset_act got %b/%b exp 0000/0000",
                     active, exit_pulse);
        else pass_cnt++;
        chk_cnt++;
        if (posx !== '0 || posy !== '0)
            $display("FAIL midreset_pos got %h/%h exp 0/0", posx, posy);
        else pass_cnt++;
        step();
        rst = 1'b1;
        step();
        chk_cnt++;
        if (active !== 4'b0 || exit_pulse !== 4'b0)
            $display("FAIL midreset_after got %b/%b exp 0000/0000",
                     active, exit_pulse);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bounce();
        test_exit();
        test_kill();
        test_pause();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
